pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: stage enables, flushes and redirect are combinational from state+inputs (0-cycle).
// A data-memory wait freezes the whole pipe; a wait longer than TIMEOUT locks it in ERROR until reset.
module pipe_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             imem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pc_redirect,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic pc_redirect;
  } ctrl_t;

  localparam ctrl_t CTRL_HOLD     = 8'b00000_00_0;
  localparam ctrl_t CTRL_REDIRECT = 8'b11111_11_1;
  localparam ctrl_t CTRL_LOAD_USE = 8'b00111_01_0;
  localparam ctrl_t CTRL_NO_FETCH = 8'b01111_10_0;
  localparam ctrl_t CTRL_RUN      = 8'b11111_00_0;

  localparam int            WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Last MEM_WAIT count before the next frozen cycle would reach TIMEOUT.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic  freeze;
  logic  load_use;
  ctrl_t ctrl;

  always_comb begin
    freeze   = dmem_req & ~dmem_ack;
    load_use = ex_is_load & (ex_rd != 5'd0) &
               ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    ctrl = CTRL_RUN;
    if (state_q == ERROR || freeze) ctrl = CTRL_HOLD;
    else if (ex_redirect)           ctrl = CTRL_REDIRECT;
    else if (load_use)              ctrl = CTRL_LOAD_USE;
    else if (!imem_ready)           ctrl = CTRL_NO_FETCH;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        wait_cnt_d = '0;
        if (freeze) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!freeze) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q >= WAIT_LAST) begin
          state_d    = ERROR;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase

    stall_cnt_d = stall_cnt_q + CNT_W'((state_q != ERROR) && !ctrl.pc_en);
    flush_cnt_d = flush_cnt_q + CNT_W'(ctrl.pc_redirect);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign id_ex_en    = ctrl.id_ex_en;
  assign ex_mem_en   = ctrl.ex_mem_en;
  assign mem_wb_en   = ctrl.mem_wb_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign pc_redirect = ctrl.pc_redirect;
  assign mem_timeout = (state_q == ERROR);
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (TIMEOUT=4/CNT_W=32 and TIMEOUT=255/CNT_W=4) share stimulus,
// checked every cycle against a priority-rule model plus directed literal expectations.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_is_load, ex_redirect, dmem_req, dmem_ack, imem_ready;

  logic pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a;
  logic if_id_flush_a, id_ex_flush_a, pc_redirect_a, mem_timeout_a;
  logic [31:0] stall_a, flush_a;
  logic pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b;
  logic if_id_flush_b, id_ex_flush_b, pc_redirect_b, mem_timeout_b;
  logic [3:0] stall_b, flush_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .imem_ready(imem_ready),
    .pc_en(pc_en_a), .if_id_en(if_id_en_a), .id_ex_en(id_ex_en_a),
    .ex_mem_en(ex_mem_en_a), .mem_wb_en(mem_wb_en_a), .if_id_flush(if_id_flush_a),
    .id_ex_flush(id_ex_flush_a), .pc_redirect(pc_redirect_a), .mem_timeout(mem_timeout_a),
    .stall_cnt(stall_a), .flush_cnt(flush_a));

  pipe_ctrl #(.TIMEOUT(255), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .imem_ready(imem_ready),
    .pc_en(pc_en_b), .if_id_en(if_id_en_b), .id_ex_en(id_ex_en_b),
    .ex_mem_en(ex_mem_en_b), .mem_wb_en(mem_wb_en_b), .if_id_flush(if_id_flush_b),
    .id_ex_flush(id_ex_flush_b), .pc_redirect(pc_redirect_b), .mem_timeout(mem_timeout_b),
    .stall_cnt(stall_b), .flush_cnt(flush_b));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: what the control word must be, derived from the priority rules.
  // Bit order {pc_en,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,if_id_flush,id_ex_flush,pc_redirect,mem_timeout}
  function automatic logic [8:0] exp_ctrl(input bit in_err);
    bit frz, lu;
    frz = dmem_req && !dmem_ack;
    lu  = ex_is_load && ex_rd != 0 &&
          ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (in_err)       return 9'b00000_00_0_1;
    if (frz)          return 9'b00000_00_0_0;
    if (ex_redirect)  return 9'b11111_11_1_0;
    if (lu)           return 9'b00111_01_0_0;
    if (!imem_ready)  return 9'b01111_10_0_0;
    return 9'b11111_00_0_0;
  endfunction

  int     m_tmo [2] = '{4, 255};
  longint m_mask[2] = '{64'hFFFF_FFFF, 64'hF};
  bit     m_err [2] = '{0, 0};
  int     m_nfrz[2] = '{0, 0};
  longint m_stall[2] = '{0, 0};
  longint m_flush[2] = '{0, 0};

  // Error after TIMEOUT+1 consecutive frozen cycles; counters plain integers, wrapped on compare.
  always @(posedge clk or negedge rst_n) begin
    logic [8:0] e;
    bit frz;
    frz = dmem_req && !dmem_ack;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_err[i] = 0; m_nfrz[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
      end else begin
        e = exp_ctrl(m_err[i]);
        if (!m_err[i] && !e[8]) m_stall[i]++;
        if (e[1]) m_flush[i]++;
        if (!m_err[i]) begin
          if (frz) begin
            m_nfrz[i]++;
            if (m_nfrz[i] == m_tmo[i] + 1) m_err[i] = 1;
          end else begin
            m_nfrz[i] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("ctrl_a", {pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a,
                   if_id_flush_a, id_ex_flush_a, pc_redirect_a, mem_timeout_a}, exp_ctrl(m_err[0]));
    chk("stall_a", stall_a, m_stall[0] & m_mask[0]);
    chk("flush_a", flush_a, m_flush[0] & m_mask[0]);
    chk("ctrl_b", {pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b,
                   if_id_flush_b, id_ex_flush_b, pc_redirect_b, mem_timeout_b}, exp_ctrl(m_err[1]));
    chk("stall_b", stall_b, m_stall[1] & m_mask[1]);
    chk("flush_b", flush_b, m_flush[1] & m_mask[1]);
  end

  task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                     input logic [4:0] rd, input logic ld, input logic redir,
                     input logic req, input logic ack, input logic imr);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2; ex_rd = rd;
    ex_is_load = ld; ex_redirect = redir; dmem_req = req; dmem_ack = ack; imem_ready = imr;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #2 rst_n = 1'b0;
    mid();
    chk("rst_pc_en", pc_en_a, 1);
    chk("rst_flushes", {if_id_flush_a, id_ex_flush_a, pc_redirect_a}, 0);
    chk("rst_stall", stall_a, 0);
    chk("rst_timeout", mem_timeout_a, 0);
    cyc(); cyc();
    rst_n = 1'b1;

    // single load-use hazard on rs1
    drv(5, 0, 1, 0, 5, 1, 0, 0, 0, 1);
    mid();
    chk("lu_pc_if", {pc_en_a, if_id_en_a}, 2'b00);
    chk("lu_idex_flush", id_ex_flush_a, 1);
    cyc(); idle(); mid();
    chk("lu_stall_cnt", stall_a, 1);
    cyc();

    // ex_rd = x0 never stalls
    drv(0, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    mid();
    chk("rd0_enables", {pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a}, 5'b11111);
    cyc();

    // redirect beats load-use and fetch miss
    drv(5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
    mid();
    chk("redir_outs", {pc_redirect_a, if_id_flush_a, id_ex_flush_a, pc_en_a}, 4'b1111);
    cyc(); idle(); mid();
    chk("redir_flush_cnt", flush_a, 1);
    cyc();

    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("imiss_outs", {pc_en_a, if_id_en_a, if_id_flush_a}, 3'b011);
    cyc();

    // load-use holds IF/ID even on a fetch miss
    drv(5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
    mid();
    chk("lu_imiss", {if_id_en_a, if_id_flush_a, id_ex_flush_a}, 3'b001);
    cyc();

    drv(7, 9, 0, 1, 9, 1, 0, 0, 0, 1);
    mid();
    chk("lu_rs2", pc_en_a, 0);
    cyc();
    drv(9, 7, 0, 1, 9, 1, 0, 0, 0, 1);
    mid();
    chk("rs1_unused", pc_en_a, 1);
    cyc();

    // zero-wait memory access
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    mid();
    chk("zero_wait", {pc_en_a, mem_wb_en_a}, 2'b11);
    cyc(); idle(); mid();
    chk("stall_cnt4", stall_a, 4);
    cyc();

    // freeze dominates redirect
    drv(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    mid();
    chk("frz_over_redir", {pc_redirect_a, pc_en_a}, 2'b00);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    mid();
    chk("ack_cycle", pc_en_a, 1);
    cyc();

    rst_n = 1'b0; idle(); mid();
    chk("rst2_cnts", {stall_a, flush_a}, 64'd0);
    cyc(); rst_n = 1'b1;

    // three-cycle memory wait
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("wait_enables", {pc_en_a, ex_mem_en_a, mem_wb_en_a}, 3'b000);
      cyc();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    mid();
    chk("wait_ack_en", {pc_en_a, mem_wb_en_a}, 2'b11);
    cyc(); idle(); mid();
    chk("wait_stall3", stall_a, 3);
    cyc();

    // timeout with TIMEOUT=4: ERROR after the fifth frozen cycle
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("pre_timeout", mem_timeout_a, 0);
      cyc();
    end
    mid();
    chk("timeout_set", {mem_timeout_a, pc_en_a}, 2'b10);
    cyc();
    idle();
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("timeout_held", {mem_timeout_a, pc_en_a, pc_redirect_a}, 3'b100);
      chk("err_no_stall", stall_a, 8);
      cyc();
    end
    rst_n = 1'b0;
    #2;
    chk("async_rst", {mem_timeout_a, pc_en_a}, 2'b01);
    chk("async_rst_cnt", {stall_a, flush_a}, 64'd0);
    mid(); cyc(); rst_n = 1'b1;

    // 17 stalls wrap a 4-bit counter to 1
    drv(5, 0, 1, 0, 5, 1, 0, 0, 0, 1);
    repeat (17) cyc();
    idle(); mid();
    chk("wrap_b", stall_b, 1);
    chk("nowrap_a", stall_a, 17);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
